// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte buffer between the UART receiver and the host.
// Latency: a byte strobed on wr_valid at edge N is on rd_data with rd_valid=1 after edge N.
// Backpressure: the receiver is never stalled; a byte arriving while full without a pop is dropped and sets sticky overflow.
// Build option: define UART_RX_FIFO_AF_EN to enable the registered almost_full flag (count >= AF_LEVEL).
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              rx_clk,
  input  logic              rst_n,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic              almost_full
);

  // Parameter sanity: pointers wrap by natural overflow, so DEPTH must be exactly 2**ADDR_W.
  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must equal 2**ADDR_W");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
    $error("uart_rx_fifo: AF_LEVEL must lie in 1..DEPTH");
  end

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_nxt;
  logic              push;
  logic              pop;
  logic              drop;
  logic              ovf_q;

  // Status flags come only from registered occupancy, never from wr_valid/rd_ready.
  assign rd_valid = (count_q != '0);
  assign full     = (count_q == DEPTH_C);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a byte alongside it.
  assign pop  = rd_valid & rd_ready;
  assign push = wr_valid & (~full | pop);
  assign drop = wr_valid & ~push;

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count_q;
    if (push && !pop) begin
      count_nxt = count_q + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count_q - 1'b1;
    end
  end

  // Byte storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge rx_clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_nxt;
    end
  end

  // Sticky overflow; a fresh drop wins over a simultaneous clear so no loss goes unreported.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_AF_EN
  localparam logic [ADDR_W:0] AF_C = (ADDR_W+1)'(AF_LEVEL);
  logic af_q;

  // almost_full is registered together with count, computed from the next occupancy.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      af_q <= 1'b0;
    end else begin
      af_q <= (count_nxt >= AF_C);
    end
  end
  assign almost_full = af_q;
`else
  assign almost_full = 1'b0;
`endif

endmodule
